// File: rtl/mcpu_alu_arbiter_if.sv
// Requester and ALU-facing signal bundle for mcpu_alu_arbiter.
// The slave modport is the arbiter itself. The master modport is the environment:
// both requesters plus the shared ALU.
interface mcpu_alu_arbiter_if #(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 16
);
  logic                 req0;
  logic [CMD_SIZE-1:0]  cmd0;
  logic [WORD_SIZE-1:0] a0;
  logic [WORD_SIZE-1:0] b0;
  logic                 ack0;
  logic                 done0;

  logic                 req1;
  logic [CMD_SIZE-1:0]  cmd1;
  logic [WORD_SIZE-1:0] a1;
  logic [WORD_SIZE-1:0] b1;
  logic                 ack1;
  logic                 done1;

  logic [WORD_SIZE-1:0] result;
  logic                 result_cf;
  logic                 result_err;
  logic                 busy;

  logic [CMD_SIZE-1:0]  alu_cmd;
  logic [WORD_SIZE-1:0] alu_in1;
  logic [WORD_SIZE-1:0] alu_in2;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_cf;

  modport slave (
    input  req0, cmd0, a0, b0, req1, cmd1, a1, b1, alu_out, alu_cf,
    output ack0, done0, ack1, done1, result, result_cf, result_err, busy,
           alu_cmd, alu_in1, alu_in2
  );

  modport master (
    output req0, cmd0, a0, b0, req1, cmd1, a1, b1, alu_out, alu_cf,
    input  ack0, done0, ack1, done1, result, result_cf, result_err, busy,
           alu_cmd, alu_in1, alu_in2
  );
endinterface

// File: rtl/mcpu_alu_arbiter.sv
// Round-robin arbiter that shares one MCPU_Alu between two requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no operation in flight; arbitrate between req0 and req1
// SETTLE  | ALU inputs frozen; count down the settle time, capture on the last count
// CAPTURE | result and done are visible for one cycle; busy drops on exit
module mcpu_alu_arbiter #(
  parameter int CMD_SIZE      = 3,
  parameter int WORD_SIZE     = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                clk,
  input logic                reset,
  mcpu_alu_arbiter_if.slave  bus
);

  localparam logic [CMD_SIZE-1:0] CMD_ADD     = CMD_SIZE'(3);
  localparam logic [CMD_SIZE-1:0] CMD_MAX     = CMD_SIZE'(5);
  localparam logic [3:0]          SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       gnt;
  logic       pick_valid;
  logic       pick;

  // When both ports request, the port that was not served last wins.
  always_comb begin
    pick_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) pick = ~last_grant;
    else                      pick = bus.req1;
  end

  // Sequencer. The capture is taken on the edge that ends the settle window,
  // so the result and done are both visible during the CAPTURE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      last_grant     <= 1'b1;
      gnt            <= 1'b0;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.result     <= '0;
      bus.result_cf  <= 1'b0;
      bus.result_err <= 1'b0;
      bus.alu_cmd    <= '0;
      bus.alu_in1    <= '0;
      bus.alu_in2    <= '0;
    end else begin
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt         <= pick;
            bus.alu_cmd <= pick ? bus.cmd1 : bus.cmd0;
            bus.alu_in1 <= pick ? bus.a1   : bus.a0;
            bus.alu_in2 <= pick ? bus.b1   : bus.b0;
            bus.ack0    <= ~pick;
            bus.ack1    <= pick;
            bus.busy    <= 1'b1;
            cnt         <= SETTLE_LOAD;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          // <= rather than == so that a zero load cannot wrap the counter
          if (cnt <= 4'd1) begin
            if (bus.alu_cmd > CMD_MAX) begin
              bus.result     <= '0;
              bus.result_cf  <= 1'b0;
              bus.result_err <= 1'b1;
            end else begin
              bus.result     <= bus.alu_out;
              bus.result_cf  <= (bus.alu_cmd == CMD_ADD) & bus.alu_cf;
              bus.result_err <= 1'b0;
            end
            bus.done0  <= ~gnt;
            bus.done1  <= gnt;
            last_grant <= gnt;
            state      <= CAPTURE;
          end
        end
        CAPTURE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
